// File: rtl/inst_mem_pkg.sv
// Shared types and default parameter values for the instruction memory sequencer.
package inst_mem_pkg;

    localparam int          DEF_DEPTH        = 64;
    localparam logic [31:0] DEF_BASE_ADDR    = 32'h0000_0000;
    localparam int          DEF_DRAIN_CYCLES = 5;
    localparam logic [31:0] DEF_NOP_INST     = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        LOADED = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/inst_mem_seq_if.sv
// Program-load handshake plus the core fetch path between a host/core and inst_mem_seq.
interface inst_mem_seq_if;

    // Load handshake: a word transfers on any rising clk edge where load_valid && load_ready.
    // The master holds load_data/load_last stable while load_valid is high and not yet accepted.
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_last;

    logic        stall;
    logic [31:0] InstAddr;
    logic [31:0] Instruction;

    modport master (
        output load_valid, load_data, load_last, stall, InstAddr,
        input  load_ready, Instruction
    );

    modport slave (
        input  load_valid, load_data, load_last, stall, InstAddr,
        output load_ready, Instruction
    );

endinterface

// File: rtl/inst_mem_array.sv
// Instruction storage: synchronous write, asynchronous read, contents not reset.
module inst_mem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_mem_seq.sv
// Loads a program word by word, then serves it to a core by fetch address and
// feeds NOPs for a fixed drain period once the core runs past the last word.
module inst_mem_seq
    import inst_mem_pkg::*;
#(
    parameter int          DEPTH        = DEF_DEPTH,
    parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
    parameter int          DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter logic [31:0] NOP_INST     = DEF_NOP_INST,
    localparam int         AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    inst_mem_seq_if.slave bus,
    input  logic          start,
    input  logic          clear,
    output logic          done,
    output logic [AW:0]   prog_len,
    output logic [31:0]   inst_count,
    output logic          oob_err,
    output state_t        state_dbg
);

    state_t      state, next_state;
    logic [AW:0] wptr;
    logic [31:0] drain_cnt;
    logic [31:0] idx;
    logic [31:0] rdata;
    logic        aligned, in_range, real_inst;
    logic        load_ready, load_hs, fill_end, enter_run, run_to_drain;
    logic [31:0] instruction;

    // Fetch decode; stale words beyond prog_len are never visible.
    assign idx       = (bus.InstAddr - BASE_ADDR) >> 2;
    assign aligned   = (bus.InstAddr[1:0] == 2'b00);
    assign in_range  = aligned && (idx < 32'(wptr));
    assign real_inst = (state == RUN) && in_range;

    assign load_hs      = bus.load_valid && load_ready && !clear;
    assign fill_end     = ((wptr + 1'b1) == (AW+1)'(DEPTH));
    assign enter_run    = start && !clear && ((state == LOADED) || (state == DONE));
    assign run_to_drain = (state == RUN) && !bus.stall && aligned && !in_range;

    inst_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk   (clk),
        .we    (load_hs),
        .waddr (wptr[AW-1:0]),
        .wdata (bus.load_data),
        .raddr (idx[AW-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, LOAD: if (load_hs) next_state = (bus.load_last || fill_end) ? LOADED : LOAD;
                LOADED:     if (start) next_state = RUN;
                RUN:        if (run_to_drain) next_state = DRAIN;
                DRAIN:      if (!bus.stall && drain_cnt <= 32'd1) next_state = DONE;
                DONE:       if (start) next_state = RUN;
                default:    next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        load_ready  = ((state == IDLE) || (state == LOAD)) && (wptr < (AW+1)'(DEPTH));
        done        = (state == DONE);
        instruction = real_inst ? rdata : NOP_INST;
    end

    // wptr doubles as prog_len: after each accepted word it equals the words stored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr       <= '0;
            drain_cnt  <= '0;
            inst_count <= '0;
            oob_err    <= 1'b0;
        end else if (clear) begin
            wptr       <= '0;
            drain_cnt  <= '0;
            inst_count <= '0;
            oob_err    <= 1'b0;
        end else begin
            if (load_hs) wptr <= wptr + 1'b1;
            if (enter_run)
                inst_count <= '0;
            else if (real_inst && !bus.stall && inst_count != 32'hFFFF_FFFF)
                inst_count <= inst_count + 32'd1;
            if ((state == RUN) && !aligned) oob_err <= 1'b1;
            if (run_to_drain)
                drain_cnt <= 32'(DRAIN_CYCLES);
            else if ((state == DRAIN) && !bus.stall && drain_cnt != 32'd0)
                drain_cnt <= drain_cnt - 32'd1;
        end
    end

    assign bus.load_ready  = load_ready;
    assign bus.Instruction = instruction;
    assign prog_len        = wptr;
    assign state_dbg       = state;

endmodule

// File: tb/tb_inst_mem_seq.sv
// Directed bench for inst_mem_seq: load/run/drain flow, stalls, overflow fill, clear and reset.
module tb_inst_mem_seq;
    import inst_mem_pkg::*;

    localparam int          DEPTH = 64;
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] W_LUI  = 32'hFFFF_F137;  // lui  x2,0xfffff
    localparam logic [31:0] W_ADDI = 32'h0021_0113;  // addi x2,x2,2
    localparam logic [31:0] W_SLLI = 32'h0041_1193;  // slli x3,x2,4

    logic        clk;
    logic        reset;
    logic        start, clear;
    logic        done, oob_err;
    logic [AW:0] prog_len;
    logic [31:0] inst_count;
    state_t      state_dbg;

    inst_mem_seq_if bus ();

    inst_mem_seq #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .start      (start),
        .clear      (clear),
        .done       (done),
        .prog_len   (prog_len),
        .inst_count (inst_count),
        .oob_err    (oob_err),
        .state_dbg  (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] xreg [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] data, input logic last);
        bus.load_valid = 1'b1;
        bus.load_data  = data;
        bus.load_last  = last;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic load_prog();
        load_word(W_LUI, 1'b0);
        load_word(W_ADDI, 1'b0);
        load_word(W_SLLI, 1'b1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Tiny RV32I subset for the three program words.
    task automatic exec_inst(input logic [31:0] i);
        logic [4:0] rd, rs1;
        rd  = i[11:7];
        rs1 = i[19:15];
        if (rd != 5'd0) begin
            if (i[6:0] == 7'h37)
                xreg[rd] = {i[31:12], 12'h000};
            else if (i[6:0] == 7'h13 && i[14:12] == 3'd0)
                xreg[rd] = xreg[rs1] + {{20{i[31]}}, i[31:20]};
            else if (i[6:0] == 7'h13 && i[14:12] == 3'd1)
                xreg[rd] = xreg[rs1] << i[24:20];
        end
    endtask

    // Sweep addresses 0..12 from RUN; leaves the block in DRAIN.
    task automatic sweep(input string tag);
        logic [31:0] e;
        exp_q.push_back(W_LUI);
        exp_q.push_back(W_ADDI);
        exp_q.push_back(W_SLLI);
        exp_q.push_back(NOP);
        for (int a = 0; a < 4; a++) begin
            bus.InstAddr = 32'(a * 4);
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s_inst%0d", tag, a), bus.Instruction, e);
            exec_inst(bus.Instruction);
            tick();
        end
        check({tag, "_state_drain"}, 32'(state_dbg), 32'(DRAIN));
        check({tag, "_inst_count"}, inst_count, 32'd3);
    endtask

    task automatic run_drain(input int stall_at, input int stall_len, output int cycles);
        cycles = 0;
        while (!done && cycles < 40) begin
            bus.stall = (cycles >= stall_at) && (cycles < stall_at + stall_len);
            tick();
            cycles++;
        end
        bus.stall = 1'b0;
    endtask

    int n;

    initial begin
        reset = 1'b0; start = 1'b0; clear = 1'b0;
        bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
        bus.stall = 1'b0; bus.InstAddr = '0;
        for (int r = 0; r < 32; r++) xreg[r] = '0;
        #12;
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_prog_len", 32'(prog_len), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_inst_count", inst_count, 32'd0);
        check("rst_oob", 32'(oob_err), 32'd0);
        check("rst_instruction", bus.Instruction, NOP);
        tick();
        reset = 1'b1;
        tick();

        // Basic program load, run and drain
        load_prog();
        check("load_state", 32'(state_dbg), 32'(LOADED));
        check("load_prog_len", 32'(prog_len), 32'd3);
        check("load_ready_low", 32'(bus.load_ready), 32'd0);
        check("loaded_nop", bus.Instruction, NOP);
        pulse_start();
        check("run_state", 32'(state_dbg), 32'(RUN));
        sweep("run1");
        run_drain(0, 0, n);
        check("drain_cycles", 32'(n), 32'd5);
        check("done_set", 32'(done), 32'd1);
        check("x2_final", xreg[2], 32'hFFFF_F002);
        check("x3_final", xreg[3], 32'hFFFF_0020);

        // Rerun from DONE with a 3-cycle stall mid-drain
        bus.InstAddr = '0;
        pulse_start();
        check("rerun_count0", inst_count, 32'd0);
        check("rerun_done0", 32'(done), 32'd0);
        sweep("run2");
        run_drain(1, 3, n);
        check("stalled_drain_cycles", 32'(n), 32'd8);

        // Misaligned fetch sets a sticky error
        bus.InstAddr = 32'h2;
        pulse_start();
        #1;
        check("oob_nop", bus.Instruction, NOP);
        tick();
        check("oob_set", 32'(oob_err), 32'd1);
        bus.InstAddr = 32'h0;
        tick();
        check("oob_sticky", 32'(oob_err), 32'd1);
        check("oob_count", inst_count, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_state", 32'(state_dbg), 32'(IDLE));
        check("clear_oob", 32'(oob_err), 32'd0);
        check("clear_count", inst_count, 32'd0);

        // Clear beats start in LOADED
        load_word(W_LUI, 1'b1);
        check("one_word_loaded", 32'(state_dbg), 32'(LOADED));
        clear = 1'b1; start = 1'b1;
        tick();
        clear = 1'b0; start = 1'b0;
        check("clr_start_state", 32'(state_dbg), 32'(IDLE));
        check("clr_start_len", 32'(prog_len), 32'd0);

        // Clear discards a concurrent load word
        load_word(W_LUI, 1'b0);
        bus.load_valid = 1'b1; bus.load_data = W_ADDI; clear = 1'b1;
        tick();
        bus.load_valid = 1'b0; clear = 1'b0;
        check("clr_load_len", 32'(prog_len), 32'd0);
        check("clr_load_state", 32'(state_dbg), 32'(IDLE));

        // Reset asserted mid-RUN
        load_prog();
        bus.InstAddr = '0;
        pulse_start();
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_len", 32'(prog_len), 32'd0);
        check("mid_rst_count", inst_count, 32'd0);
        check("mid_rst_oob", 32'(oob_err), 32'd0);
        check("mid_rst_inst", bus.Instruction, NOP);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_inst", bus.Instruction, NOP);

        // Fill the whole array without load_last
        for (int k = 0; k < DEPTH; k++) load_word(32'(k) ^ 32'hA5A5_0000, 1'b0);
        check("full_ready_low", 32'(bus.load_ready), 32'd0);
        check("full_len", 32'(prog_len), 32'(DEPTH));
        check("full_state", 32'(state_dbg), 32'(LOADED));
        bus.InstAddr = 32'(4 * (DEPTH - 1));
        pulse_start();
        check("full_last_word", bus.Instruction, 32'(DEPTH - 1) ^ 32'hA5A5_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
